// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock controller: FSM encoding, default
// divider-bit / debounce parameters and a small edge helper.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_HI   = 2'd2,
        S_LO   = 2'd3
    } cpu_state_e;

    localparam int DEB_BIT_DEF  = 17;
    localparam int DEB_CNT_DEF  = 4;
    localparam int FAST_BIT_DEF = 2;
    localparam int SLOW_BIT_DEF = 24;

    function automatic logic edge_rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step-button conditioning: 2-flop synchronizer, tick-sampled debounce counter
// and a one-cycle press pulse on the accepted 0->1 transition.
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic tick,
    output logic press
);

    localparam int CW = $clog2(DEB_CNT);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // the DEB_CNT-th consecutive differing sample is the one that flips
        if (tick) begin
            if (sync2_q != stable_q) begin
                if (cnt_q == CW'(DEB_CNT - 1)) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: free-running or single-stepped Clk_CPU derived from the
// upstream divider, with a debounced step button and a Clk_CPU rising-edge count.
//
// state  | meaning
// S_RUN  | Clk_CPU toggles on every run tick
// S_HALT | step mode, Clk_CPU parked low, waiting for a press
// S_HI   | single-step high phase, ends on the next fast tick
// S_LO   | single-step low phase, ends on the next fast tick
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DEB_BIT  = DEB_BIT_DEF,
    parameter int DEB_CNT  = DEB_CNT_DEF,
    parameter int FAST_BIT = FAST_BIT_DEF,
    parameter int SLOW_BIT = SLOW_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        SW2,
    input  logic        SW_STEP,
    input  logic        BTN_STEP,
    output logic        Clk_CPU,
    output logic        Clk_CPU_en,
    output logic        step_busy,
    output logic [15:0] cpu_cycles
);

    cpu_state_e  state_q, state_d;
    logic        clk_cpu_q, clk_cpu_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic [15:0] cycles_q, cycles_d;
    logic        fast_prev_q, fast_prev_d;
    logic        slow_prev_q, slow_prev_d;
    logic        deb_prev_q, deb_prev_d;

    logic        fast_tick, slow_tick, deb_tick, run_tick;
    logic        press;
    logic        clkdiv_unused;

    assign clkdiv_unused = ^clkdiv;

    always_comb begin
        fast_prev_d = clkdiv[FAST_BIT];
        slow_prev_d = clkdiv[SLOW_BIT];
        deb_prev_d  = clkdiv[DEB_BIT];
        fast_tick   = edge_rise(clkdiv[FAST_BIT], fast_prev_q);
        slow_tick   = edge_rise(clkdiv[SLOW_BIT], slow_prev_q);
        deb_tick    = edge_rise(clkdiv[DEB_BIT], deb_prev_q);
        run_tick    = SW2 ? slow_tick : fast_tick;
    end

    btn_debounce #(
        .DEB_CNT(DEB_CNT)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(BTN_STEP),
        .tick   (deb_tick),
        .press  (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            clk_cpu_q   <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            cycles_q    <= 16'd0;
            fast_prev_q <= 1'b0;
            slow_prev_q <= 1'b0;
            deb_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cpu_q   <= clk_cpu_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            cycles_q    <= cycles_d;
            fast_prev_q <= fast_prev_d;
            slow_prev_q <= slow_prev_d;
            deb_prev_q  <= deb_prev_d;
        end
    end

    // Halting only from a low phase that is not toggling keeps high phases whole.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (!run_tick && SW_STEP && !clk_cpu_q) state_d = S_HALT;
            S_HALT:  if (!SW_STEP) state_d = S_RUN;
                     else if (press) state_d = S_HI;
            S_HI:    if (fast_tick) state_d = S_LO;
            S_LO:    if (fast_tick) state_d = SW_STEP ? S_HALT : S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        clk_cpu_d = clk_cpu_q;
        case (state_q)
            S_RUN:   if (run_tick) clk_cpu_d = ~clk_cpu_q;
            S_HALT:  clk_cpu_d = SW_STEP & press;
            S_HI:    clk_cpu_d = ~fast_tick;
            S_LO:    clk_cpu_d = 1'b0;
            default: clk_cpu_d = 1'b0;
        endcase
        en_d     = clk_cpu_d & ~clk_cpu_q;
        cycles_d = cycles_q + 16'(en_d);
        busy_d   = (state_d == S_HI) | (state_d == S_LO);
    end

    assign Clk_CPU    = clk_cpu_q;
    assign Clk_CPU_en = en_q;
    assign step_busy  = busy_q;
    assign cpu_cycles = cycles_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized bench for cpu_clk_ctrl against a behavioural model, plus a few
// literal timing expectations for free run, halting, stepping and reset.
module tb_cpu_clk_ctrl;

    localparam int FB = 2;
    localparam int SB = 5;
    localparam int DB = 3;
    localparam int DC = 4;

    localparam int M_RUN      = 0;
    localparam int M_HALTED   = 1;
    localparam int M_PULSE_HI = 2;
    localparam int M_PULSE_LO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clkdiv;
    logic        SW2 = 1'b0;
    logic        SW_STEP = 1'b0;
    logic        BTN_STEP = 1'b0;
    logic        Clk_CPU, Clk_CPU_en, step_busy;
    logic [15:0] cpu_cycles;

    int n_vec = 0;
    int n_err = 0;
    int obs_en, obs_hi, obs_busy;

    // behavioural model state
    bit          m_valid = 1'b0;
    int          m_mode;
    logic        m_clk, m_en, m_busy;
    logic [15:0] m_cycles;
    logic        m_sync1, m_sync2, m_level, m_press;
    int          m_diff;
    logic        m_pf, m_ps, m_pd;

    cpu_clk_ctrl #(
        .DEB_BIT (DB),
        .DEB_CNT (DC),
        .FAST_BIT(FB),
        .SLOW_BIT(SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clkdiv    (clkdiv),
        .SW2       (SW2),
        .SW_STEP   (SW_STEP),
        .BTN_STEP  (BTN_STEP),
        .Clk_CPU   (Clk_CPU),
        .Clk_CPU_en(Clk_CPU_en),
        .step_busy (step_busy),
        .cpu_cycles(cpu_cycles)
    );

    always #5 clk = ~clk;

    // upstream free-running divider
    initial begin
        clkdiv = $urandom;
        forever begin
            @(posedge clk);
            clkdiv <= clkdiv + 32'd1;
        end
    end

    initial begin
        logic ft, st, dt, rt, nclk, npress;
        int   nmode;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid  = 1'b1;
                m_mode   = M_RUN;
                m_clk    = 1'b0;
                m_en     = 1'b0;
                m_busy   = 1'b0;
                m_cycles = 16'd0;
                m_sync1  = 1'b0;
                m_sync2  = 1'b0;
                m_level  = 1'b0;
                m_press  = 1'b0;
                m_diff   = 0;
                m_pf     = 1'b0;
                m_ps     = 1'b0;
                m_pd     = 1'b0;
            end else begin
                ft = clkdiv[FB] && !m_pf;
                st = clkdiv[SB] && !m_ps;
                dt = clkdiv[DB] && !m_pd;
                rt = SW2 ? st : ft;
                nmode = m_mode;
                nclk  = m_clk;
                case (m_mode)
                    M_RUN: begin
                        if (rt) nclk = !m_clk;
                        else if (SW_STEP && !m_clk) nmode = M_HALTED;
                    end
                    M_HALTED: begin
                        if (!SW_STEP) nmode = M_RUN;
                        else if (m_press) begin
                            nmode = M_PULSE_HI;
                            nclk  = 1'b1;
                        end
                    end
                    M_PULSE_HI: begin
                        if (ft) begin
                            nmode = M_PULSE_LO;
                            nclk  = 1'b0;
                        end
                    end
                    default: begin
                        if (ft) nmode = SW_STEP ? M_HALTED : M_RUN;
                    end
                endcase
                m_en     = nclk && !m_clk;
                m_cycles = m_cycles + (m_en ? 16'd1 : 16'd0);
                m_clk    = nclk;
                m_mode   = nmode;
                m_busy   = (nmode == M_PULSE_HI) || (nmode == M_PULSE_LO);
                npress = 1'b0;
                if (dt) begin
                    if (m_sync2 != m_level) begin
                        m_diff = m_diff + 1;
                        if (m_diff == DC) begin
                            m_level = !m_level;
                            m_diff  = 0;
                            npress  = m_level;
                        end
                    end else begin
                        m_diff = 0;
                    end
                end
                m_press = npress;
                m_sync2 = m_sync1;
                m_sync1 = BTN_STEP;
                m_pf = clkdiv[FB];
                m_ps = clkdiv[SB];
                m_pd = clkdiv[DB];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_vec++;
                if ({Clk_CPU, Clk_CPU_en, step_busy, cpu_cycles} !==
                    {m_clk, m_en, m_busy, m_cycles}) begin
                    n_err++;
                    $display("FAIL model_cmp t=%0t got clk=%b en=%b busy=%b cyc=%0d want clk=%b en=%b busy=%b cyc=%0d",
                             $time, Clk_CPU, Clk_CPU_en, step_busy, cpu_cycles,
                             m_clk, m_en, m_busy, m_cycles);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_en(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (Clk_CPU_en) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic hold_btn(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_en   += int'(Clk_CPU_en);
            obs_hi   += int'(Clk_CPU);
            obs_busy += int'(step_busy);
            BTN_STEP = v;
        end
    endtask

    task automatic clear_obs();
        obs_en   = 0;
        obs_hi   = 0;
        obs_busy = 0;
    endtask

    initial begin
        int  w;
        bit  found;
        repeat (3) @(negedge clk);
        check("rst_clk", int'(Clk_CPU), 0);
        check("rst_cycles", int'(cpu_cycles), 0);
        check("rst_busy", int'(step_busy), 0);
        rst = 1'b0;

        // free run, fast tick
        w = -1;
        for (int k = 0; k < 10; k++) wait_en(40, w);
        check("run_period", w, 16);
        check("run_cycles10", int'(cpu_cycles), 10);

        SW2 = 1'b1;
        repeat (400) @(negedge clk);
        SW2 = 1'b0;
        repeat (40) @(negedge clk);

        // request a halt while Clk_CPU is high
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (Clk_CPU) found = 1'b1;
        end
        check("find_high", int'(found), 1);
        SW_STEP = 1'b1;
        repeat (40) @(negedge clk);
        clear_obs();
        hold_btn(1'b0, 500);
        check("halt_hi_cycles", obs_hi, 0);
        check("halt_en", obs_en, 0);

        // bouncing press then clean hold
        clear_obs();
        for (int b = 0; b < 3; b++) begin
            hold_btn(1'b1, 8);
            hold_btn(1'b0, 8);
        end
        hold_btn(1'b1, 100);
        hold_btn(1'b0, 120);
        check("step_en", obs_en, 1);
        check("step_lo_phase", obs_busy - obs_hi, 8);
        check("step_hi_range", int'(obs_hi >= 1 && obs_hi <= 8), 1);

        // another press from halt
        clear_obs();
        hold_btn(1'b1, 100);
        hold_btn(1'b0, 120);
        check("step2_en", obs_en, 1);

        // reset in the middle of the high phase
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            hold_btn(1'b1, 1);
            if (step_busy && Clk_CPU) found = 1'b1;
        end
        check("find_step_hi", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        BTN_STEP = 1'b0;
        SW_STEP  = 1'b0;
        check("midrst_clk", int'(Clk_CPU), 0);
        check("midrst_cycles", int'(cpu_cycles), 0);
        check("midrst_busy", int'(step_busy), 0);
        check("midrst_en", int'(Clk_CPU_en), 0);
        for (int k = 0; k < 3; k++) wait_en(40, w);
        check("rerun_period", w, 16);

        // randomized mix
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(3) == 0) SW2 = ~SW2;
            if ($urandom_range(2) == 0) SW_STEP = 1'($urandom_range(1));
            if ($urandom_range(40) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold_btn(1'($urandom_range(1)), $urandom_range(120, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
